// File: rtl/gpio_pulse_responder_pkg.sv
// Shared types for the GPIO pulse responder.
// Mode decode folds the reserved encoding onto TOGGLE.
package gpio_pulse_responder_pkg;

   typedef enum logic [1:0] {
      TOGGLE = 2'b00,
      PULSE  = 2'b01,
      LEVEL  = 2'b10
   } mode_e;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      FIRE,
      DONE
   } state_e;

   function automatic mode_e decode_mode(input logic [1:0] m);
      case (m)
         2'b01:   return PULSE;
         2'b10:   return LEVEL;
         default: return TOGGLE;
      endcase
   endfunction

endpackage

// File: rtl/gpio_pulse_responder_ch.sv
// One responder channel: edge detect, FSM, edge counter
// and pulse timer.
module gpio_pulse_responder_ch
   import gpio_pulse_responder_pkg::*;
#(
   parameter int unsigned CntWidth = 8,
   parameter int unsigned PulseLen = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                en_i,
   input  logic                clear_i,
   input  logic [1:0]          mode_i,
   input  logic [CntWidth-1:0] cnt_max_i,
   input  logic                gpio_i,
   output logic                gpio_o,
   output logic [CntWidth-1:0] cnt_o,
   output logic                done_o
);

   localparam int unsigned PtW =
      (PulseLen > 1) ? $clog2(PulseLen) : 1;
   localparam logic [PtW-1:0] PtReload = PtW'(PulseLen - 1);

   state_e              state_q, state_d;
   mode_e               mode_q, mode_d;
   logic [CntWidth-1:0] max_q, max_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic [PtW-1:0]      ptimer_q, ptimer_d;
   logic                gpio_q, gpio_d;
   logic                out_q, out_d;
   logic                done_q, done_d;
   logic                rise;
   logic                fire;
   logic [CntWidth-1:0] cnt_inc;

   assign rise    = gpio_i & ~gpio_q;
   assign cnt_inc = cnt_q + CntWidth'(1);
   assign fire    = (cnt_inc == max_q);

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      max_d    = max_q;
      cnt_d    = cnt_q;
      ptimer_d = ptimer_q;
      gpio_d   = gpio_i;
      out_d    = out_q;
      done_d   = done_q;
      if (!en_i) begin
         state_d  = IDLE;
         cnt_d    = '0;
         ptimer_d = '0;
         out_d    = 1'b0;
         done_d   = 1'b0;
      end else if (state_q == IDLE || clear_i) begin
         // Arming and re-arming both re-latch the config.
         state_d  = ARMED;
         mode_d   = decode_mode(mode_i);
         max_d    = (cnt_max_i == '0) ? CntWidth'(1) : cnt_max_i;
         cnt_d    = '0;
         ptimer_d = '0;
         out_d    = 1'b0;
         done_d   = 1'b0;
      end else begin
         case (state_q)
            ARMED: begin
               if (rise && fire) begin
                  cnt_d = '0;
                  case (mode_q)
                     PULSE: begin
                        out_d    = 1'b1;
                        ptimer_d = PtReload;
                        state_d  = FIRE;
                     end
                     LEVEL: begin
                        cnt_d   = cnt_q;
                        out_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                     end
                     default: out_d = ~out_q;
                  endcase
               end else if (rise) begin
                  cnt_d = cnt_inc;
               end
            end
            FIRE: begin
               if (rise && fire) begin
                  cnt_d    = '0;
                  ptimer_d = PtReload;
               end else begin
                  if (rise) cnt_d = cnt_inc;
                  if (ptimer_q == '0) begin
                     out_d   = 1'b0;
                     state_d = ARMED;
                  end else begin
                     ptimer_d = ptimer_q - PtW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         mode_q   <= TOGGLE;
         max_q    <= CntWidth'(1);
         cnt_q    <= '0;
         ptimer_q <= '0;
         gpio_q   <= 1'b0;
         out_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         max_q    <= max_d;
         cnt_q    <= cnt_d;
         ptimer_q <= ptimer_d;
         gpio_q   <= gpio_d;
         out_q    <= out_d;
         done_q   <= done_d;
      end
   end

   assign gpio_o = out_q;
   assign cnt_o  = cnt_q;
   assign done_o = done_q;

endmodule

// File: rtl/gpio_pulse_responder.sv
// N-channel GPIO responder; replicates the channel and
// slices the packed per-channel buses.
module gpio_pulse_responder
   import gpio_pulse_responder_pkg::*;
#(
   parameter int unsigned NumCh    = 4,
   parameter int unsigned CntWidth = 8,
   parameter int unsigned PulseLen = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NumCh-1:0]          en_i,
   input  logic [NumCh-1:0]          clear_i,
   input  logic [2*NumCh-1:0]        mode_i,
   input  logic [CntWidth*NumCh-1:0] cnt_max_i,
   input  logic [NumCh-1:0]          gpio_i,
   output logic [NumCh-1:0]          gpio_o,
   output logic [CntWidth*NumCh-1:0] cnt_o,
   output logic [NumCh-1:0]          done_o
);

   for (genvar c = 0; c < NumCh; c++) begin : g_ch
      gpio_pulse_responder_ch #(
         .CntWidth (CntWidth),
         .PulseLen (PulseLen)
      ) u_ch (
         .clk_i     (clk_i),
         .rst_ni    (rst_ni),
         .en_i      (en_i[c]),
         .clear_i   (clear_i[c]),
         .mode_i    (mode_i[2*c +: 2]),
         .cnt_max_i (cnt_max_i[CntWidth*c +: CntWidth]),
         .gpio_i    (gpio_i[c]),
         .gpio_o    (gpio_o[c]),
         .cnt_o     (cnt_o[CntWidth*c +: CntWidth]),
         .done_o    (done_o[c])
      );
   end

endmodule

// File: tb/tb_gpio_pulse_responder.sv
// Directed bench for gpio_pulse_responder; inputs change
// and outputs are sampled on the falling clock edge.
module tb_gpio_pulse_responder;

   logic        clk;
   logic        rst_ni;
   logic [3:0]  en_i;
   logic [3:0]  clear_i;
   logic [7:0]  mode_i;
   logic [31:0] cnt_max_i;
   logic [3:0]  gpio_i;
   logic [3:0]  gpio_o;
   logic [31:0] cnt_o;
   logic [3:0]  done_o;

   int tests;
   int fails;

   gpio_pulse_responder #(
      .NumCh    (4),
      .CntWidth (8),
      .PulseLen (4)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_ni),
      .en_i      (en_i),
      .clear_i   (clear_i),
      .mode_i    (mode_i),
      .cnt_max_i (cnt_max_i),
      .gpio_i    (gpio_i),
      .gpio_o    (gpio_o),
      .cnt_o     (cnt_o),
      .done_o    (done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic setup(input int c, input logic [1:0] m,
                        input logic [7:0] mx);
      en_i[c] = 1'b0;
      mode_i[2*c +: 2] = m;
      cnt_max_i[8*c +: 8] = mx;
      @(negedge clk);
      en_i[c] = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_in(input int c);
      gpio_i[c] = 1'b1;
      @(negedge clk);
      gpio_i[c] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_ni = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if (gpio_o !== 4'h0) begin
         fails++;
         $display("FAIL reset_gpio got %h exp 0", gpio_o);
      end
      tests++;
      if (cnt_o !== 32'h0) begin
         fails++;
         $display("FAIL reset_cnt got %h exp 0", cnt_o);
      end
      tests++;
      if (done_o !== 4'h0) begin
         fails++;
         $display("FAIL reset_done got %h exp 0", done_o);
      end
      rst_ni = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_count;
      setup(0, 2'b00, 8'd3);
      pulse_in(0);
      pulse_in(0);
      tests++;
      if (cnt_o[7:0] !== 8'd2) begin
         fails++;
         $display("FAIL midrst_pre got %0d exp 2", cnt_o[7:0]);
      end
      rst_ni = 1'b0;
      @(negedge clk);
      rst_ni = 1'b1;
      tests++;
      if (cnt_o[7:0] !== 8'd0 || gpio_o[0] !== 1'b0) begin
         fails++;
         $display("FAIL midrst_clr got cnt %0d gpio %b exp 0 0",
                  cnt_o[7:0], gpio_o[0]);
      end
      @(negedge clk);
      pulse_in(0);
      pulse_in(0);
      tests++;
      if (gpio_o[0] !== 1'b0) begin
         fails++;
         $display("FAIL midrst_early got %b exp 0", gpio_o[0]);
      end
      pulse_in(0);
      tests++;
      if (gpio_o[0] !== 1'b1 || cnt_o[7:0] !== 8'd0) begin
         fails++;
         $display("FAIL midrst_fire got gpio %b cnt %0d exp 1 0",
                  gpio_o[0], cnt_o[7:0]);
      end
   endtask

   task automatic test_toggle_periodic;
      logic exp;
      setup(0, 2'b00, 8'd16);
      for (int i = 1; i <= 48; i++) begin
         pulse_in(0);
         if (i % 16 == 0) begin
            exp = ((i / 16) % 2) == 1;
            tests++;
            if (gpio_o[0] !== exp) begin
               fails++;
               $display("FAIL toggle_rise%0d got %b exp %b",
                        i, gpio_o[0], exp);
            end
         end
         if (i == 40) begin
            tests++;
            if (cnt_o[7:0] !== 8'd8) begin
               fails++;
               $display("FAIL toggle_cnt40 got %0d exp 8", cnt_o[7:0]);
            end
         end
      end
      tests++;
      if (cnt_o[7:0] !== 8'd0) begin
         fails++;
         $display("FAIL toggle_cnt_end got %0d exp 0", cnt_o[7:0]);
      end
   endtask

   task automatic test_pulse_extend;
      int hi;
      setup(1, 2'b01, 8'd2);
      pulse_in(1);
      gpio_i[1] = 1'b1;
      @(negedge clk);
      hi = 0;
      for (int i = 0; i < 16; i++) begin
         if (gpio_o[1]) hi++;
         gpio_i[1] = 1'b0;
         @(negedge clk);
      end
      tests++;
      if (hi != 4) begin
         fails++;
         $display("FAIL pulse_len got %0d exp 4", hi);
      end
      pulse_in(1);
      gpio_i[1] = 1'b1;
      @(negedge clk);
      hi = 0;
      for (int i = 0; i < 16; i++) begin
         if (gpio_o[1]) hi++;
         gpio_i[1] = (i == 1 || i == 3);
         @(negedge clk);
      end
      tests++;
      if (hi != 8) begin
         fails++;
         $display("FAIL pulse_extend got %0d exp 8", hi);
      end
      tests++;
      if (cnt_o[15:8] !== 8'd0 || gpio_o[1] !== 1'b0) begin
         fails++;
         $display("FAIL pulse_end got cnt %0d gpio %b exp 0 0",
                  cnt_o[15:8], gpio_o[1]);
      end
   endtask

   task automatic test_level_clear;
      setup(2, 2'b10, 8'd5);
      for (int i = 1; i <= 7; i++) begin
         pulse_in(2);
         if (i == 4) begin
            tests++;
            if (gpio_o[2] !== 1'b0 || done_o[2] !== 1'b0) begin
               fails++;
               $display("FAIL level_r4 got gpio %b done %b exp 0 0",
                        gpio_o[2], done_o[2]);
            end
         end
         if (i == 5) begin
            tests++;
            if (gpio_o[2] !== 1'b1 || done_o[2] !== 1'b1) begin
               fails++;
               $display("FAIL level_r5 got gpio %b done %b exp 1 1",
                        gpio_o[2], done_o[2]);
            end
         end
      end
      tests++;
      if (cnt_o[23:16] !== 8'd4 || done_o !== 4'b0100) begin
         fails++;
         $display("FAIL level_frozen got cnt %0d done %b exp 4 0100",
                  cnt_o[23:16], done_o);
      end
      gpio_i[2] = 1'b1;
      clear_i[2] = 1'b1;
      @(negedge clk);
      gpio_i[2] = 1'b0;
      clear_i[2] = 1'b0;
      @(negedge clk);
      tests++;
      if (cnt_o[23:16] !== 8'd0 || gpio_o[2] !== 1'b0 ||
          done_o[2] !== 1'b0) begin
         fails++;
         $display("FAIL level_clear got cnt %0d gpio %b done %b exp 0",
                  cnt_o[23:16], gpio_o[2], done_o[2]);
      end
      for (int i = 1; i <= 4; i++) pulse_in(2);
      tests++;
      if (cnt_o[23:16] !== 8'd4 || done_o[2] !== 1'b0) begin
         fails++;
         $display("FAIL level_rearm4 got cnt %0d done %b exp 4 0",
                  cnt_o[23:16], done_o[2]);
      end
      pulse_in(2);
      tests++;
      if (gpio_o[2] !== 1'b1 || done_o[2] !== 1'b1) begin
         fails++;
         $display("FAIL level_refire got gpio %b done %b exp 1 1",
                  gpio_o[2], done_o[2]);
      end
   endtask

   task automatic test_thresh0_disable;
      logic exp;
      setup(3, 2'b00, 8'd0);
      for (int i = 1; i <= 3; i++) begin
         pulse_in(3);
         exp = (i % 2) == 1;
         tests++;
         if (gpio_o[3] !== exp || cnt_o[31:24] !== 8'd0) begin
            fails++;
            $display("FAIL thr0_rise%0d got gpio %b cnt %0d exp %b 0",
                     i, gpio_o[3], cnt_o[31:24], exp);
         end
      end
      en_i[3] = 1'b0;
      @(negedge clk);
      tests++;
      if (gpio_o[3] !== 1'b0) begin
         fails++;
         $display("FAIL dis_gpio got %b exp 0", gpio_o[3]);
      end
      pulse_in(3);
      pulse_in(3);
      tests++;
      if (gpio_o[3] !== 1'b0 || cnt_o[31:24] !== 8'd0) begin
         fails++;
         $display("FAIL dis_nocount got gpio %b cnt %0d exp 0 0",
                  gpio_o[3], cnt_o[31:24]);
      end
      en_i[3] = 1'b1;
      @(negedge clk);
      pulse_in(3);
      tests++;
      if (gpio_o[3] !== 1'b1) begin
         fails++;
         $display("FAIL reen_rise got %b exp 1", gpio_o[3]);
      end
   endtask

   task automatic test_independence;
      logic [3:0] sched [11];
      sched = '{4'b1101, 4'b0011, 4'b1011, 4'b0011, 4'b1011,
                4'b0101, 4'b1001, 4'b0001, 4'b1001, 4'b0101,
                4'b0001};
      en_i = 4'h0;
      mode_i = {2'b11, 2'b10, 2'b01, 2'b00};
      cnt_max_i = {8'd1, 8'd2, 8'd3, 8'd2};
      @(negedge clk);
      en_i = 4'hf;
      @(negedge clk);
      for (int s = 0; s < 11; s++) begin
         gpio_i = sched[s];
         @(negedge clk);
         if (s == 3) begin
            tests++;
            if (gpio_o[1] !== 1'b1) begin
               fails++;
               $display("FAIL indep_pulse got %b exp 1", gpio_o[1]);
            end
         end
         gpio_i = 4'h0;
         @(negedge clk);
      end
      repeat (10) @(negedge clk);
      tests++;
      if (gpio_o !== 4'b1101) begin
         fails++;
         $display("FAIL indep_gpio got %b exp 1101", gpio_o);
      end
      tests++;
      if (cnt_o !== 32'h00_01_01_01) begin
         fails++;
         $display("FAIL indep_cnt got %h exp 00010101", cnt_o);
      end
      tests++;
      if (done_o !== 4'b0100) begin
         fails++;
         $display("FAIL indep_done got %b exp 0100", done_o);
      end
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      rst_ni    = 1'b0;
      en_i      = 4'h0;
      clear_i   = 4'h0;
      mode_i    = 8'h0;
      cnt_max_i = 32'h0;
      gpio_i    = 4'h0;
      @(negedge clk);
      test_reset;
      test_reset_mid_count;
      test_toggle_periodic;
      test_pulse_extend;
      test_level_clear;
      test_thresh0_disable;
      test_independence;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/gpio_pulse_responder.md
# gpio_pulse_responder

Multi-channel GPIO stimulus responder for the system testbench and FPGA self-test. Each channel detects rising edges on its `gpio_i` line, counts them against a per-channel threshold, and answers on `gpio_o` with a toggle, a fixed-length pulse, or a sticky level, depending on the channel mode. It generalises the single-channel fixed-threshold GPIO counter to N channels with runtime thresholds, three response modes and readable status. It sits beside the SoC top and loops back onto spare GPIO pins.

## Interface
- `NumCh`, 4: number of independent channels.
- `CntWidth`, 8: width of the edge counter and threshold.
- `PulseLen`, 4: `gpio_o` high time in PULSE mode, in cycles. Must be ≥1.
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset; synchronous, active-low.
- `en_i`  in  NumCh  per-channel enable.
- `clear_i`  in  NumCh  per-channel clear/re-arm, single-cycle strobe.
- `mode_i`  in  2*NumCh  per-channel mode; channel c uses bits [2c+1:2c].
- `cnt_max_i`  in  CntWidth*NumCh  per-channel threshold.
- `gpio_i`  in  NumCh  monitored lines, synchronous to `clk_i`.
- `gpio_o`  out  NumCh  response lines.
- `cnt_o`  out  CntWidth*NumCh  current edge count per channel.
- `done_o`  out  NumCh  sticky threshold-reached flag, LEVEL mode only.

## Operation
- Edge detect: `gpio_q` is registered every cycle in every state. A rise is `gpio_i & ~gpio_q`. Rises count only in ARMED and FIRE.
- Per-channel states:
  - IDLE → ARMED when `en_i` is high. `mode_i` and `cnt_max_i` are latched on this transition and on every clear/re-arm.
  - A threshold of 0 is treated as 1.
- Counting: each counted rise increments `cnt`. The rise that makes `cnt+1 == max` is the firing edge: `cnt` returns to 0 on that edge and the mode action is taken.
  - TOGGLE (2'b00, and 2'b11 as reserved alias): `gpio_o` inverts, state stays ARMED. The channel is periodic.
  - PULSE (2'b01): `gpio_o`=1 and the state moves to FIRE with `ptimer`=PulseLen-1. FIRE decrements `ptimer` each cycle. When `ptimer` is 0, FIRE → ARMED with `gpio_o`=0.
    - Rises during FIRE are counted.
    - A firing edge during FIRE reloads `ptimer`, which extends the pulse.
  - LEVEL (2'b10): `gpio_o`=1, `done_o`=1, state moves to DONE. In DONE, `cnt_o` is frozen at max-1 and rises are ignored.
- `clear_i` in ARMED, FIRE or DONE:
  - `cnt`=0, `gpio_o`=0, `done_o`=0, pulse aborted.
  - State → ARMED, threshold and mode re-latched.
- Priority, highest first: `rst_ni` low, `en_i` low, `clear_i`, rise.
  - `en_i` low forces IDLE next edge and clears `cnt`, `gpio_o` and `done_o`.
  - A clear coincident with a rise drops the rise.
- Counter width: `cnt` never exceeds max-1, so no wrap is possible.

## Timing
- All outputs are registered. Reset values: `gpio_o`=0, `cnt_o`=0, `done_o`=0, state IDLE, `gpio_q`=0.
- Reset applies on any edge with `rst_ni`=0, including mid-pulse. Outputs are 0 after that edge.
- A line held high through reset or IDLE produces no rise, because `gpio_q` tracks it.
- Latency: a rise of `gpio_i` sampled at edge k updates `cnt_o` or `gpio_o` at edge k. Outputs are visible one cycle after the input change.
- A PULSE high time is exactly PulseLen cycles when no further firing edge arrives.
- Enable: earliest counted rise is at edge k+1 after `en_i` is sampled high at edge k.
- A rise needs `gpio_i` low for at least one sampled cycle before it. Back-to-back rises are therefore at most one per 2 cycles.
- Channels are fully independent. There is no cross-channel interaction.

## Structure
- Package `gpio_pulse_responder_pkg` holds:
  - `mode_e` with values TOGGLE=2'b00, PULSE=2'b01, LEVEL=2'b10.
  - `state_e` with values IDLE, ARMED, FIRE, DONE.
  - The mode-decode function that maps 2'b11 to TOGGLE.
- Sub-module `gpio_pulse_responder_ch` is one channel: edge detect, FSM, counter and pulse timer. The top generates it NumCh times and only slices and concatenates the buses.

## Test plan
- Reset mid-count: ch0 TOGGLE, max=3, 2 rises, then `rst_ni` low for 1 cycle → `cnt_o`=0 and `gpio_o`=0. The next 3 rises after re-enable toggle `gpio_o` to 1.
- TOGGLE periodic: ch0 max=16, 48 rises → `gpio_o` toggles on rises 16, 32 and 48, ending at 1 with `cnt_o`=0.
- PULSE extend: ch1 max=2, PulseLen=4.
  - Rises 1–2 → `gpio_o` high exactly 4 cycles.
  - Re-run with rises 3–4 arriving during FIRE → high time runs from rise 2 until 4 cycles after rise 4.
- LEVEL sticky and clear: ch2 max=5.
  - 7 rises → `done_o`=1, `gpio_o`=1 from rise 5, `cnt_o` frozen at 4.
  - `clear_i` together with a rise → all 0, rise not counted.
  - The next 5 rises fire again.
- Threshold 0 and disable: ch3 max=0 TOGGLE → every rise toggles `gpio_o`. Dropping `en_i` → `gpio_o`=0 and no counting until re-enabled.
- Independence: all 4 channels in different modes with interleaved stimulus → each channel matches its own reference model exactly.
